// File: rtl/gcd_core.sv
// Iterative subtract-and-swap Euclid GCD engine with valid/ready request and
// response handshakes; one transaction in flight at a time.
module gcd_core #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2*W-1:0] req_msg,
    input  logic           req_val,
    output logic           req_rdy,
    output logic [W-1:0]   resp_msg,
    output logic           resp_val,
    input  logic           resp_rdy
);

    typedef struct packed {
        logic [W-1:0] b;
        logic [W-1:0] a;
    } gcd_req_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    gcd_req_t     req;

    assign req = gcd_req_t'(req_msg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            case (state)
                IDLE: if (req_val) begin
                    a_reg <= req.a;
                    b_reg <= req.b;
                    state <= CALC;
                end
                // Swap keeps a_reg >= b_reg so the subtraction never wraps.
                CALC: begin
                    if (a_reg < b_reg) begin
                        a_reg <= b_reg;
                        b_reg <= a_reg;
                    end else if (b_reg != '0) begin
                        a_reg <= a_reg - b_reg;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: if (resp_rdy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_rdy  = (state == IDLE);
    assign resp_val = (state == DONE);
    assign resp_msg = (state == DONE) ? a_reg : '0;

endmodule

// File: tb/tb_gcd_core.sv
// Directed scoreboard bench for gcd_core: expected GCDs come from a modulo
// Euclid reference and are queued at send time, popped at response time.
module tb_gcd_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] req_msg = '0;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic [15:0] resp_msg;
    logic        resp_val;
    logic        resp_rdy = 1'b0;

    int          npass = 0;
    int          ntot  = 0;
    logic [15:0] sb[$];

    gcd_core #(.W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_msg  (req_msg),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .resp_msg (resp_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] gcd_ref(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x = a;
        logic [15:0] y = b;
        logic [15:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input bit push);
        int n = 0;
        while (!req_rdy && n < 100) begin
            step();
            n++;
        end
        chk("req_rdy_before_send", {31'd0, req_rdy}, 32'd1);
        req_msg = {b, a};
        req_val = 1'b1;
        step();
        req_val = 1'b0;
        if (push) sb.push_back(gcd_ref(a, b));
    endtask

    // Counts edges after the accepting edge until resp_val; req_rdy must stay low.
    task automatic wait_resp(input string tag, input int budget, output int lat);
        bit rdy_hi = 1'b0;
        lat = 0;
        while (!resp_val && lat < budget) begin
            if (req_rdy) rdy_hi = 1'b1;
            step();
            lat++;
        end
        chk({tag, "_resp_val"}, {31'd0, resp_val}, 32'd1);
        chk({tag, "_req_rdy_low"}, {31'd0, rdy_hi}, 32'd0);
    endtask

    task automatic take_resp(input string tag);
        logic [15:0] exp;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_msg"}, {16'd0, resp_msg}, {16'd0, exp});
        end
        resp_rdy = 1'b1;
        step();
        resp_rdy = 1'b0;
        chk({tag, "_resp_val_drop"}, {31'd0, resp_val}, 32'd0);
        chk({tag, "_req_rdy_back"}, {31'd0, req_rdy}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b);
        int lat;
        send(a, b, 1'b1);
        wait_resp(tag, 70000, lat);
        take_resp(tag);
    endtask

    initial begin
        int  lat;
        bit  seen;

        // Reset held for two cycles
        step();
        step();
        chk("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("rst_resp_val", {31'd0, resp_val}, 32'd0);
        chk("rst_resp_msg", {16'd0, resp_msg}, 32'd0);
        reset = 1'b1;
        step();
        chk("post_rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("post_rst_resp_val", {31'd0, resp_val}, 32'd0);
        chk("post_rst_resp_msg", {16'd0, resp_msg}, 32'd0);

        // (16,8): exactly 4 edges after acceptance
        send(16'd16, 16'd8, 1'b1);
        wait_resp("g16_8", 100, lat);
        chk("g16_8_latency", lat, 32'd4);
        take_resp("g16_8");

        // (15,12) under backpressure: value stable for 10 cycles
        send(16'd15, 16'd12, 1'b1);
        wait_resp("g15_12", 100, lat);
        for (int i = 0; i < 10; i++) begin
            chk("bp_resp_val", {31'd0, resp_val}, 32'd1);
            chk("bp_resp_msg", {16'd0, resp_msg}, 32'd3);
            step();
        end
        take_resp("g15_12");

        // Truncation-width operand patterns
        run("trunc1", 16'd21943, 16'd19438);
        run("trunc2", 16'd7607, 16'd62464);

        // Boundary operands
        run("g0_0", 16'd0, 16'd0);
        run("g0_5", 16'd0, 16'd5);
        run("g7_0", 16'd7, 16'd0);
        run("g9_9", 16'd9, 16'd9);

        // Reset during CALC aborts the transaction
        send(16'd15, 16'd12, 1'b0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("midrst_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("midrst_resp_val", {31'd0, resp_val}, 32'd0);
        chk("midrst_resp_msg", {16'd0, resp_msg}, 32'd0);
        step();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (resp_val) seen = 1'b1;
            step();
        end
        chk("midrst_no_resp", {31'd0, seen}, 32'd0);
        chk("midrst_idle", {31'd0, req_rdy}, 32'd1);

        // req_val held high with other operands during CALC/DONE is ignored
        send(16'd16, 16'd8, 1'b1);
        req_msg = {16'd12, 16'd15};
        req_val = 1'b1;
        wait_resp("ign", 100, lat);
        chk("ign_latency", lat, 32'd4);
        step();
        step();
        chk("ign_hold_msg", {16'd0, resp_msg}, 32'd8);
        req_val = 1'b0;
        take_resp("ign");

        // Back-to-back, in order
        send(16'd16, 16'd8, 1'b1);
        wait_resp("b2b_a", 100, lat);
        take_resp("b2b_a");
        send(16'd15, 16'd12, 1'b1);
        wait_resp("b2b_b", 100, lat);
        take_resp("b2b_b");

        // Worst case: long subtract chain must still finish
        run("g65535_1", 16'd65535, 16'd1);

        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
